// File: rtl/fht_result_reader.sv
// fht_result_reader: unloads fht_top result banks in bit-reversed row order and streams samples in natural order
module fht_result_reader #(
    parameter int D_BIT  = 22,
    parameter int A_BIT  = 8,
    parameter int RD_LAT = 2
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iRDY,
    output logic [A_BIT-1:0] oADDR_RD,
    input  logic [D_BIT-1:0] iDATA_0,
    input  logic [D_BIT-1:0] iDATA_1,
    input  logic [D_BIT-1:0] iDATA_2,
    input  logic [D_BIT-1:0] iDATA_3,
    output logic [D_BIT-1:0] oDATA,
    output logic             oVALID,
    input  logic             iREADY,
    output logic             oLAST,
    output logic             oBUSY,
    output logic             oDONE
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_CAPTURE, S_SEND} state_t;

    localparam logic [1:0]       LAT_END  = 2'(RD_LAT > 1 ? RD_LAT - 2 : 0);
    localparam logic [A_BIT-1:0] ROW_LAST = '1;

    state_t           r_state, w_state_nx;
    logic             r_rdy_d;
    logic [A_BIT-1:0] r_row, w_row_nx;
    logic [1:0]       r_bank, w_bank_nx;
    logic [1:0]       r_lat, w_lat_nx;
    logic [A_BIT-1:0] r_addr;
    logic [D_BIT-1:0] r_buf [4];
    logic             r_done, w_done_nx;
    logic             w_start;

    function automatic logic [A_BIT-1:0] bitrev(input logic [A_BIT-1:0] v);
        logic [A_BIT-1:0] res;
        for (int i = 0; i < A_BIT; i++) res[i] = v[A_BIT-1-i];
        return res;
    endfunction

    // Only a rising edge of iRDY seen from IDLE starts an unload
    assign w_start = (r_state == S_IDLE) && iRDY && !r_rdy_d;

    // Next-state and counter updates; a low iRDY outside IDLE aborts and freezes counters
    always_comb begin
        w_state_nx = r_state;
        w_row_nx   = r_row;
        w_bank_nx  = r_bank;
        w_lat_nx   = r_lat;
        w_done_nx  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nx = S_ADDR;
                    w_row_nx   = '0;
                end
            end
            S_ADDR: begin
                w_state_nx = (RD_LAT > 1) ? S_WAIT : S_CAPTURE;
                w_lat_nx   = '0;
            end
            S_WAIT: begin
                if (r_lat == LAT_END) w_state_nx = S_CAPTURE;
                else w_lat_nx = r_lat + 2'd1;
            end
            S_CAPTURE: begin
                w_state_nx = S_SEND;
                w_bank_nx  = '0;
            end
            S_SEND: begin
                if (iREADY) begin
                    w_bank_nx = r_bank + 2'd1;
                    if (r_bank == 2'd3) begin
                        if (r_row == ROW_LAST) begin
                            w_state_nx = S_IDLE;
                            w_done_nx  = 1'b1;
                        end else begin
                            w_row_nx   = r_row + 1'b1;
                            w_state_nx = S_ADDR;
                        end
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
        if (r_state != S_IDLE && !iRDY) begin
            w_state_nx = S_IDLE;
            w_row_nx   = r_row;
            w_bank_nx  = r_bank;
            w_done_nx  = 1'b0;
        end
    end

    // State, counters, read address and row buffer; iRDY history resets high so a level-high iRDY after reset cannot start
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_state <= S_IDLE;
            r_rdy_d <= 1'b1;
            r_row   <= '0;
            r_bank  <= '0;
            r_lat   <= '0;
            r_addr  <= '0;
            r_buf   <= '{default: '0};
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_rdy_d <= iRDY;
            r_row   <= w_row_nx;
            r_bank  <= w_bank_nx;
            r_lat   <= w_lat_nx;
            r_done  <= w_done_nx;
            if (w_state_nx == S_ADDR) r_addr <= bitrev(w_row_nx);
            if (r_state == S_CAPTURE) r_buf <= '{iDATA_0, iDATA_1, iDATA_2, iDATA_3};
        end
    end

    assign oADDR_RD = r_addr;
    assign oDATA    = r_buf[r_bank];
    assign oVALID   = (r_state == S_SEND);
    assign oLAST    = oVALID && (r_bank == 2'd3) && (r_row == ROW_LAST);
    assign oBUSY    = (r_state != S_IDLE);
    assign oDONE    = r_done;
endmodule
